gt_writeback_buffer: RTL and testbench

- Drain side of the victim cache eviction path.
- Accepts 256-bit dirty lines pushed out of the victim cache (line plus address), holds them in a small FIFO, and writes them to main memory over a req/ack handshake.
- Provides a combinational lookup port so a victim-cache miss can still hit on a line that is waiting to drain, and reads never see stale memory.

---
 rtl/gt_writeback_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_gt_writeback_buffer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gt_writeback_buffer.sv
// ---------------------------------------------------------------------------
// gt_writeback_buffer
//
// Drain side of the victim-cache eviction path. Dirty 256-bit lines pushed
// out of the victim cache are held in a small FIFO and written to main
// memory over a req/ack handshake, strictly in push order. A combinational
// lookup port lets a victim-cache miss hit on a line that is still waiting
// to drain, so reads never see stale memory.
//
// Optional feature (macro WB_COALESCE_EN):
//   A push whose line address matches a buffered entry other than the head
//   overwrites that entry's data in place instead of allocating. Such a push
//   is accepted even when the buffer is full. Without the macro every push
//   allocates, and duplicate addresses drain twice, in order.
//
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   in_valid/in_addr/   evicted line from the victim cache; in_ready says the
//   in_data/in_ready    buffer takes it at this edge
//   mem_wr_req/addr/    write to main memory; addr is line aligned, addr and
//   data, mem_wr_ack    data stay stable until ack
//   lk_addr/lk_hit/     combinational lookup; youngest matching entry wins,
//   lk_data             lk_data is zero on a miss
//   count, empty        occupancy (0..DEPTH) and count==0
// ---------------------------------------------------------------------------
module gt_writeback_buffer #(
    parameter int DEPTH       = 4,
    parameter int LINE_BITS   = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   in_valid,
    input  logic [31:0]            in_addr,
    input  logic [LINE_BITS-1:0]   in_data,
    output logic                   in_ready,
    output logic                   mem_wr_req,
    output logic [31:0]            mem_wr_addr,
    output logic [LINE_BITS-1:0]   mem_wr_data,
    input  logic                   mem_wr_ack,
    input  logic [31:0]            lk_addr,
    output logic                   lk_hit,
    output logic [LINE_BITS-1:0]   lk_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = 32 - OFFSET_BITS;

    typedef enum logic {IDLE, REQ} state_t;
    state_t state;

    logic [TAG_W-1:0]     tagMem  [DEPTH];
    logic [LINE_BITS-1:0] lineMem [DEPTH];
    logic [DEPTH-1:0]     entryValid;
    logic [PTR_W-1:0]     wrPtr;
    logic [PTR_W-1:0]     rdPtr;
    logic [PTR_W-1:0]     nextRdPtr;
    logic [TAG_W-1:0]     memWrTag;

    logic [TAG_W-1:0]     inTag;
    logic [TAG_W-1:0]     lkTag;
    logic                 unusedOffsetBits;

    logic                 coalHit;
    logic [PTR_W-1:0]     coalIdx;
    logic                 pushFire;
    logic                 allocFire;
    logic                 popFire;
    logic                 loadNow;
    logic [PTR_W-1:0]     loadIdx;
    logic [LINE_BITS-1:0] loadData;

    // ageIdx[0] is the oldest slot (head), ageIdx[DEPTH-1] the youngest
    // possible slot; scanning in this order lets the last match win.
    logic [PTR_W-1:0]     ageIdx [DEPTH];

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : genAge
            assign ageIdx[g] = rdPtr + PTR_W'(g);
        end
    endgenerate

    assign inTag            = in_addr[31:OFFSET_BITS];
    assign lkTag            = lk_addr[31:OFFSET_BITS];
    assign unusedOffsetBits = ^{in_addr[OFFSET_BITS-1:0], lk_addr[OFFSET_BITS-1:0]};
    assign nextRdPtr        = rdPtr + PTR_W'(1);

`ifdef WB_COALESCE_EN
    // The head is never a coalescing target: whenever the buffer is
    // non-empty the head is either in REQ or being loaded on this edge.
    always_comb begin
        coalHit = 1'b0;
        coalIdx = rdPtr;
        for (int i = 1; i < DEPTH; i++) begin
            if (entryValid[ageIdx[i]] && (tagMem[ageIdx[i]] == inTag)) begin
                coalHit = 1'b1;
                coalIdx = ageIdx[i];
            end
        end
    end
`else
    assign coalHit = 1'b0;
    assign coalIdx = rdPtr;
`endif

    assign in_ready  = (count != CNT_W'(DEPTH)) || coalHit;
    assign pushFire  = in_valid && in_ready;
    assign allocFire = pushFire && !coalHit;
    assign popFire   = (state == REQ) && mem_wr_ack;
    assign empty     = (count == '0);

    assign mem_wr_addr = {memWrTag, {OFFSET_BITS{1'b0}}};

    // Head load: from IDLE the current head starts a write; in REQ an ack
    // with more lines behind it loads the next head on the same edge.
    assign loadNow = ((state == IDLE) && (count != '0)) ||
                     (popFire && (count > CNT_W'(1)));
    assign loadIdx = (state == IDLE) ? rdPtr : nextRdPtr;

    // A coalescing push may land in the very entry that becomes the new
    // head on this edge; forward the incoming data so memory gets it.
    assign loadData = (pushFire && coalHit && (coalIdx == loadIdx)) ?
                      in_data : lineMem[loadIdx];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            mem_wr_req  <= 1'b0;
            memWrTag    <= '0;
            mem_wr_data <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            entryValid  <= '0;
        end else begin
            if (allocFire) begin
                wrPtr             <= wrPtr + PTR_W'(1);
                entryValid[wrPtr] <= 1'b1;
            end
            if (popFire) begin
                rdPtr             <= nextRdPtr;
                entryValid[rdPtr] <= 1'b0;
            end

            case ({allocFire, popFire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (loadNow) begin
                memWrTag    <= tagMem[loadIdx];
                mem_wr_data <= loadData;
            end

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state      <= REQ;
                        mem_wr_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_wr_ack && (count == CNT_W'(1))) begin
                        state      <= IDLE;
                        mem_wr_req <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_wr_req <= 1'b0;
                end
            endcase
        end
    end

    // Line storage carries no reset; entryValid gates every use of it.
    always_ff @(posedge CLK) begin
        if (allocFire) begin
            tagMem[wrPtr]  <= inTag;
            lineMem[wrPtr] <= in_data;
        end else if (pushFire && coalHit) begin
            lineMem[coalIdx] <= in_data;
        end
    end

    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[ageIdx[i]] && (tagMem[ageIdx[i]] == lkTag)) begin
                lk_hit  = 1'b1;
                lk_data = lineMem[ageIdx[i]];
            end
        end
    end

endmodule

// File: tb/tb_gt_writeback_buffer.sv
// ---------------------------------------------------------------------------
// tb_gt_writeback_buffer
//
// Directed scenarios (reset, single drain, fill/back-pressure, lookup,
// duplicate address, async reset during a write) followed by a randomized
// run. A queue of buffered lines serves as the reference: pushes append,
// acknowledged writes pop the front, lookups search from the youngest end.
// ---------------------------------------------------------------------------
module tb_gt_writeback_buffer;
    localparam int DEPTH = 4;

`ifdef WB_COALESCE_EN
    localparam bit COAL_EN = 1'b1;
`else
    localparam bit COAL_EN = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         in_valid;
    logic [31:0]  in_addr;
    logic [255:0] in_data;
    logic         in_ready;
    logic         mem_wr_req;
    logic [31:0]  mem_wr_addr;
    logic [255:0] mem_wr_data;
    logic         mem_wr_ack;
    logic [31:0]  lk_addr;
    logic         lk_hit;
    logic [255:0] lk_data;
    logic [2:0]   count;
    logic         empty;

    always #5 CLK = ~CLK;

    gt_writeback_buffer #(.DEPTH(DEPTH), .LINE_BITS(256), .OFFSET_BITS(5)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .count(count), .empty(empty)
    );

    typedef struct packed {
        logic [26:0]  tag;
        logic [255:0] data;
    } ent_t;

    ent_t         mq[$];
    logic [31:0]  drainA[$];
    logic [255:0] drainD[$];
    logic [31:0]  pushedA[$];
    int           checks = 0;
    int           errors = 0;
    bit           lastPush;
    logic [26:0]  nextTag = 27'h4000000;

    task automatic chkv(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] qa(input int i);
        if (i < drainA.size()) return drainA[i];
        return 'x;
    endfunction

    function automatic logic [255:0] qd(input int i);
        if (i < drainD.size()) return drainD[i];
        return 'x;
    endfunction

    // Index of the youngest non-head entry a push would coalesce into, or -1.
    function automatic int modelCoal(input logic [31:0] a);
        int r;
        r = -1;
        if (COAL_EN) begin
            for (int j = 1; j < mq.size(); j++)
                if (mq[j].tag == a[31:5]) r = j;
        end
        return r;
    endfunction

    task automatic modelLookup(input logic [31:0] a, output bit hit, output logic [255:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == a[31:5]) begin
                hit = 1'b1;
                d   = mq[i].data;
            end
        end
    endtask

    task automatic checkState(input string tag);
        bit           h;
        logic [255:0] d;
        int           ci;
        modelLookup(lk_addr, h, d);
        ci = modelCoal(in_addr);
        chkv({tag, " count"}, 256'(count), 256'(mq.size()));
        chkb({tag, " empty"}, empty, mq.size() == 0);
        chkb({tag, " in_ready"}, in_ready, (mq.size() < DEPTH) || (ci >= 0));
        chkb({tag, " lk_hit"}, lk_hit, h);
        chkv({tag, " lk_data"}, lk_data, d);
        if (mq.size() == 0) begin
            chkb({tag, " req idle"}, mem_wr_req, 1'b0);
        end else if (mem_wr_req) begin
            chkv({tag, " head addr"}, 256'(mem_wr_addr), 256'({mq[0].tag, 5'b0}));
            chkv({tag, " head data"}, mem_wr_data, mq[0].data);
        end
    endtask

    // Advance one clock edge and apply the same edge to the reference.
    task automatic tick();
        int ci;
        bit pf, pp;
        ci = modelCoal(in_addr);
        pf = in_valid && ((mq.size() < DEPTH) || (ci >= 0));
        pp = mem_wr_req && mem_wr_ack;
        if (pp) begin
            drainA.push_back(mem_wr_addr);
            drainD.push_back(mem_wr_data);
            if (mq.size() > 0) begin
                chkv("write addr", 256'(mem_wr_addr), 256'({mq[0].tag, 5'b0}));
                chkv("write data", mem_wr_data, mq[0].data);
            end
        end
        @(posedge CLK);
        if (pp && mq.size() > 0) begin
            void'(mq.pop_front());
            if (ci >= 0) ci--;
        end
        if (pf) begin
            if (ci >= 0) mq[ci].data = in_data;
            else         mq.push_back({in_addr[31:5], in_data});
        end
        lastPush = pf;
        #1;
    endtask

    task automatic drainAll(input string tag);
        mem_wr_ack = 1'b1;
        for (int k = 0; k < 40 && mq.size() > 0; k++) begin
            checkState(tag);
            tick();
        end
        mem_wr_ack = 1'b0;
        #1;
        chkv({tag, " drained count"}, 256'(count), 256'(0));
        chkb({tag, " drained empty"}, empty, 1'b1);
    endtask

    task automatic push(input logic [31:0] a, input logic [255:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        #1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [255:0] d1, dL, dA, dB, dC;
        logic [31:0]  expOrder [5];
        d1 = 256'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666_5555_4444_3333_2222_1111_0000;
        expOrder[0] = 32'h01000000; expOrder[1] = 32'h02000000; expOrder[2] = 32'h03000000;
        expOrder[3] = 32'h04000000; expOrder[4] = 32'h05000000;

        RST_N = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        mem_wr_ack = 1'b0; lk_addr = 32'h03000003; lastPush = 1'b0;

        // Reset / idle
        repeat (2) @(posedge CLK);
        #2;
        chkv("rst count", 256'(count), 256'(0));
        chkb("rst empty", empty, 1'b1);
        chkb("rst in_ready", in_ready, 1'b1);
        chkb("rst req", mem_wr_req, 1'b0);
        chkb("rst lk_hit", lk_hit, 1'b0);
        chkv("rst lk_data", lk_data, 256'(0));
        chkv("rst wr addr", 256'(mem_wr_addr), 256'(0));
        chkv("rst wr data", mem_wr_data, 256'(0));
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        checkState("idle");

        // Single drain, ack three cycles after req rises
        drainA.delete(); drainD.delete();
        push(32'h01000001, d1);
        #1;
        chkb("sd req after push", mem_wr_req, 1'b0);
        chkv("sd count after push", 256'(count), 256'(1));
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chkb("sd req held", mem_wr_req, 1'b1);
            chkv("sd addr held", 256'(mem_wr_addr), 256'(32'h01000000));
            chkv("sd data held", mem_wr_data, d1);
            chkv("sd count held", 256'(count), 256'(1));
            if (k == 2) mem_wr_ack = 1'b1;
            tick();
        end
        mem_wr_ack = 1'b0;
        #1;
        chkb("sd req falls", mem_wr_req, 1'b0);
        chkv("sd count zero", 256'(count), 256'(0));
        chkv("sd drained addr", 256'(qa(0)), 256'(32'h01000000));
        chkv("sd drained data", qd(0), d1);

        // Fill and back-pressure
        drainA.delete(); drainD.delete();
        for (int k = 1; k <= 4; k++) begin
            logic [31:0] a;
            a = (32'(k) << 24) | 32'(k);
            push(a, rand256());
        end
        in_valid = 1'b1; in_addr = 32'h05000005; in_data = rand256();
        #1;
        chkb("fill in_ready full", in_ready, 1'b0);
        chkv("fill count full", 256'(count), 256'(4));
        checkState("fill");
        tick();
        #1;
        chkv("fill not accepted", 256'(count), 256'(4));
        mem_wr_ack = 1'b1;
        #1;
        tick();
        mem_wr_ack = 1'b0;
        #1;
        chkv("fill count after pop", 256'(count), 256'(3));
        chkb("fill in_ready after pop", in_ready, 1'b1);
        chkv("fill first drained", 256'(qa(0)), 256'(32'h01000000));
        tick();
        in_valid = 1'b0;
        #1;
        chkv("fill count refilled", 256'(count), 256'(4));
        drainAll("fill");
        chkv("fill drain n", 256'(drainA.size()), 256'(5));
        for (int k = 0; k < 5; k++)
            chkv($sformatf("fill order %0d", k), 256'(qa(k)), 256'(expOrder[k]));

        // Lookup hit / miss
        dL = rand256();
        push(32'h03000003, dL);
        lk_addr = 32'h03000010;
        #1;
        chkb("lk hit", lk_hit, 1'b1);
        chkv("lk hit data", lk_data, dL);
        lk_addr = 32'h07000007;
        #1;
        chkb("lk miss", lk_hit, 1'b0);
        chkv("lk miss data", lk_data, 256'(0));
        drainAll("lk");

        // Duplicate address
        drainA.delete(); drainD.delete();
        dA = rand256(); dB = rand256(); dC = rand256();
        push(32'h02000002, dA);
        push(32'h02000002, dB);
        lk_addr = 32'h02000002;
        #1;
        chkv("dup count", 256'(count), 256'(2));
        chkv("dup lk data", lk_data, dB);
`ifdef WB_COALESCE_EN
        push(32'h02000002, dC);
        #1;
        chkv("dup coal count", 256'(count), 256'(2));
        chkv("dup coal lk data", lk_data, dC);
        drainAll("dup");
        chkv("dup drain n", 256'(drainA.size()), 256'(2));
        chkv("dup first data", qd(0), dA);
        chkv("dup second data", qd(1), dC);
`else
        drainAll("dup");
        chkv("dup drain n", 256'(drainA.size()), 256'(2));
        chkv("dup first data", qd(0), dA);
        chkv("dup second data", qd(1), dB);
`endif
        chkv("dup second addr", 256'(qa(1)), 256'(32'h02000000));

        // Asynchronous reset while a write is pending
        push(32'h0A000000, rand256());
        push(32'h0B000000, rand256());
        push(32'h0C000000, rand256());
        lk_addr = 32'h0A000004;
        #1;
        chkb("ar req before", mem_wr_req, 1'b1);
        chkv("ar count before", 256'(count), 256'(3));
        chkb("ar lk before", lk_hit, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chkb("ar req dropped", mem_wr_req, 1'b0);
        chkv("ar count", 256'(count), 256'(0));
        chkb("ar empty", empty, 1'b1);
        chkb("ar in_ready", in_ready, 1'b1);
        chkb("ar lk cleared", lk_hit, 1'b0);
        mq.delete();
        #2;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        checkState("ar after");

        // Randomized traffic against the reference queue
        lastPush = 1'b1;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (lastPush || !in_valid) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_addr  = {nextTag, 5'($urandom)};
                nextTag  = nextTag + 27'd1;
                in_data  = rand256();
                pushedA.push_back(in_addr);
            end
            mem_wr_ack = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0 || pushedA.size() == 0)
                lk_addr = $urandom;
            else
                lk_addr = {pushedA[$urandom_range(0, pushedA.size() - 1)][31:5], 5'($urandom)};
            #1;
            checkState("rnd");
            tick();
        end
        in_valid = 1'b0;
        drainAll("rnd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
